// File: rtl/weight_stream_buffer_pkg.sv
// Shared helpers for the weight stream buffer: frame-length derivation.
package weight_stream_buffer_pkg;

  // Beats per frame; never below one, so a single-beat frame has every beat marked last.
  function automatic int frame_beats(input int tensor_size, input int par_dim_0);
    return (tensor_size / par_dim_0 < 1) ? 1 : tensor_size / par_dim_0;
  endfunction

endpackage

// File: rtl/weight_stream_fifo_mem.sv
// Beat storage for the weight stream buffer: one write port, asynchronous head read.
module weight_stream_fifo_mem #(
  parameter int DEPTH     = 4,
  parameter int NUM_LANES = 1,
  parameter int VEC_W     = 16,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [PTR_W-1:0]                waddr,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] wdata,
  input  logic [PTR_W-1:0]                raddr,
  output logic [NUM_LANES-1:0][VEC_W-1:0] rdata
);

  logic [NUM_LANES-1:0][VEC_W-1:0] mem [DEPTH];

  // Storage needs no reset: occupancy gates whether the head is meaningful.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/weight_stream_buffer.sv
// Rate-decoupling FIFO between the weight ROM stream and the matmul stage,
// tagging each output beat with last-of-frame and a frame index.
module weight_stream_buffer
  import weight_stream_buffer_pkg::*;
#(
  parameter int WEIGHT_PRECISION_0       = 16,
  parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 32,
  parameter int WEIGHT_PARALLELISM_DIM_0 = 1,
  parameter int WEIGHT_PARALLELISM_DIM_1 = 1,
  parameter int FIFO_DEPTH               = 4,
  parameter int FRAME_WIDTH              = 8,
  parameter int NUM_LANES                = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1,
  parameter int OCC_W                    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WEIGHT_PRECISION_0-1:0] data_in [NUM_LANES],
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic [WEIGHT_PRECISION_0-1:0] data_out [NUM_LANES],
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic                          data_out_last,
  output logic [FRAME_WIDTH-1:0]        data_out_frame,
  output logic [OCC_W-1:0]              occupancy
);

  localparam int OUT_DEPTH = frame_beats(WEIGHT_TENSOR_SIZE_DIM_0, WEIGHT_PARALLELISM_DIM_0);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int BEAT_W    = $clog2(OUT_DEPTH) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(OUT_DEPTH - 1);
  localparam logic [OCC_W-1:0]  FULL      = OCC_W'(FIFO_DEPTH);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [BEAT_W-1:0] out_beat;
  logic              push, pop;
  logic [NUM_LANES-1:0][WEIGHT_PRECISION_0-1:0] wr_beat, rd_beat;

  // Ready comes from registered occupancy only, so it never combinationally depends on the consumer.
  assign data_in_ready  = (occupancy != FULL);
  assign data_out_valid = (occupancy != '0);
  assign data_out_last  = data_out_valid && (out_beat == LAST_BEAT);
  assign push           = data_in_valid && data_in_ready;
  assign pop            = data_out_valid && data_out_ready;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wr_beat[l]  = data_in[l];
    assign data_out[l] = rd_beat[l];
  end

  weight_stream_fifo_mem #(
    .DEPTH     (FIFO_DEPTH),
    .NUM_LANES (NUM_LANES),
    .VEC_W     (WEIGHT_PRECISION_0),
    .PTR_W     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_beat),
    .raddr (rd_ptr),
    .rdata (rd_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occupancy      <= '0;
      out_beat       <= '0;
      data_out_frame <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
      // Frame bookkeeping follows consumed beats, not accepted ones.
      if (pop) begin
        if (out_beat == LAST_BEAT) begin
          out_beat       <= '0;
          data_out_frame <= data_out_frame + FRAME_WIDTH'(1);
        end else begin
          out_beat <= out_beat + BEAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_stream_buffer.sv
// Directed bench: two buffer configurations driven in lockstep against a queue model.
module tb_weight_stream_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic        rdy = 1'b0;
  logic [15:0] din   [1];
  logic [15:0] dout0 [1];
  logic [15:0] dout1 [1];
  logic        irdy0, ov0, last0, irdy1, ov1, last1;
  logic [7:0]  frame0;
  logic [1:0]  frame1;
  logic [2:0]  occ0, occ1;

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  int q[$];           // model contents, head first
  int popped = 0;     // model beats consumed since reset
  int last_idx[$];    // DUT0 pop ordinals that carried last
  int pops_seen = 0;
  int frames1[$];     // first DUT1 frame tags observed on pops

  always #5 clk = ~clk;

  weight_stream_buffer u_dut0 (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vin), .data_in_ready(irdy0),
    .data_out(dout0), .data_out_valid(ov0), .data_out_ready(rdy), .data_out_last(last0),
    .data_out_frame(frame0), .occupancy(occ0)
  );

  weight_stream_buffer #(.WEIGHT_TENSOR_SIZE_DIM_0(1), .FRAME_WIDTH(2)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vin), .data_in_ready(irdy1),
    .data_out(dout1), .data_out_valid(ov1), .data_out_ready(rdy), .data_out_last(last1),
    .data_out_frame(frame1), .occupancy(occ1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a bounded queue; frame/last derive from the total number of consumed beats.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      popped = 0;
    end else begin
      bit do_push, do_pop;
      do_push = vin && (q.size() != 4);
      do_pop  = (q.size() != 0) && rdy;
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (do_push) q.push_back(int'(din[0]));
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("occ0", occ0, q.size());
      chk("occ1", occ1, q.size());
      chk("in_ready0", irdy0, q.size() != 4);
      chk("in_ready1", irdy1, q.size() != 4);
      chk("out_valid0", ov0, q.size() != 0);
      chk("out_valid1", ov1, q.size() != 0);
      if (q.size() != 0) begin
        chk("data0", dout0[0], q[0]);
        chk("data1", dout1[0], q[0]);
        chk("last0", last0, (popped % 32) == 31);
        chk("frame0", frame0, (popped / 32) % 256);
        chk("last1", last1, 1);
        chk("frame1", frame1, popped % 4);
      end else begin
        chk("last0_idle", last0, 0);
        chk("last1_idle", last1, 0);
      end
      if (rst) pops_seen = 0;
      else if (ov0 && rdy) begin
        if (last0) last_idx.push_back(pops_seen);
        if (frames1.size() < 5) frames1.push_back(int'(frame1));
        pops_seen++;
      end
    end
  end

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      vin = 1'b1;
      din[0] = 16'(base + i);
      @(posedge clk); #1;
    end
    vin = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    din[0] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b1;
    // Reset state, first cycle after release
    chk("rst_occ", occ0, 0);
    chk("rst_in_ready", irdy0, 1);
    chk("rst_out_valid", ov0, 0);
    chk("rst_last", last0, 0);
    chk("rst_frame", frame0, 0);

    // Streaming 64 beats, value = index
    rdy = 1'b1;
    push_n(64, 0);
    idle(3);
    chk("stream_pops", pops_seen, 64);
    chk("stream_nlast", last_idx.size(), 2);
    if (last_idx.size() == 2) begin
      chk("stream_last_a", last_idx[0], 31);
      chk("stream_last_b", last_idx[1], 63);
    end
    chk("stream_frame", frame0, 2);
    chk("n_frames1", frames1.size(), 5);
    if (frames1.size() == 5) begin
      chk("f1_0", frames1[0], 0);
      chk("f1_1", frames1[1], 1);
      chk("f1_2", frames1[2], 2);
      chk("f1_3", frames1[3], 3);
      chk("f1_4", frames1[4], 0);
    end

    // Simultaneous push/pop holding occupancy at 2
    rdy = 1'b0;
    push_n(2, 100);
    rdy = 1'b1;
    push_n(20, 200);
    chk("steady_occ", occ0, 2);
    idle(3);

    // Fill under backpressure, then push+pop while full
    rdy = 1'b0;
    push_n(6, 300);
    chk("full_occ", occ0, 4);
    chk("full_in_ready", irdy0, 0);
    vin = 1'b1; din[0] = 16'd400; rdy = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0; rdy = 1'b0;
    chk("full_pop_occ", occ0, 3);
    chk("full_pop_in_ready", irdy0, 1);
    chk("full_pop_head", dout0[0], 301);
    rdy = 1'b1;
    idle(4);
    chk("drained_occ", occ0, 0);

    // Reset at beat 17 of frame 3 with data still queued
    rst = 1'b1; idle(1); rst = 1'b0;
    push_n(113, 0);
    idle(3);
    chk("pre_rst_frame", frame0, 3);
    chk("pre_rst_pops", pops_seen, 113);
    last_idx.delete();
    rdy = 1'b0;
    push_n(2, 500);
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("mid_rst_occ", occ0, 0);
    chk("mid_rst_valid", ov0, 0);
    chk("mid_rst_last", last0, 0);
    chk("mid_rst_frame", frame0, 0);
    chk("mid_rst_in_ready", irdy0, 1);
    rdy = 1'b1;
    push_n(32, 600);
    idle(3);
    chk("post_rst_nlast", last_idx.size(), 1);
    if (last_idx.size() == 1) chk("post_rst_last", last_idx[0], 31);
    chk("post_rst_frame", frame0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
